// File: rtl/video_rx_frame_ctrl_if.sv
// Receive-parser and frame-FIFO signal bundle for video_rx_frame_ctrl.
// Pixel width follows VIDEO_RX_RGB565_EN (16-bit RGB565 when defined, 24-bit RGB otherwise).
interface video_rx_frame_ctrl_if;
`ifdef VIDEO_RX_RGB565_EN
    localparam int PIX_W = 16;
`else
    localparam int PIX_W = 24;
`endif

    logic              rec_en;
    logic [31:0]       rec_data;
    logic              eth_rec_en;
    logic [23:0]       rec_data_24;
    logic              rec_pkt_done;
    logic [15:0]       rec_byte_num;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [PIX_W-1:0]  fifo_wr_data;

    // Strobe semantics: every parser strobe is a single-cycle qualifier with no
    // back-pressure. fifo_wr_en is a push that is only issued when fifo_full was
    // low in the cycle the write was decided.
    modport master (
        output rec_en, rec_data, eth_rec_en, rec_data_24, rec_pkt_done, rec_byte_num,
        output fifo_full,
        input  fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  rec_en, rec_data, eth_rec_en, rec_data_24, rec_pkt_done, rec_byte_num,
        input  fifo_full,
        output fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/video_rx_frame_ctrl.sv
// Frame sequencer: syncs on marker packets and gates only well-formed frame pixels into the FIFO.
// Optional feature macro VIDEO_RX_RGB565_EN packs pixels to RGB565 into the output register.
module video_rx_frame_ctrl #(
    parameter int          PKT_PIXELS = 480,
    parameter int          FRAME_PKTS = 1920,
    parameter logic [31:0] FRAME_MARK = 32'hF05A_A50F
) (
    input  logic                 clk,
    input  logic                 rst_n,
    video_rx_frame_ctrl_if.slave bus,
    output logic                 frame_sync,
    output logic                 frame_done,
    output logic                 frame_active,
    output logic [11:0]          pkt_cnt,
    output logic [7:0]           err_cnt,
    output logic [1:0]           dbg_state
);
`ifdef VIDEO_RX_RGB565_EN
    localparam int PIX_W = 16;
`else
    localparam int PIX_W = 24;
`endif
    localparam logic [15:0] PKT_BYTES    = 16'(PKT_PIXELS * 3);
    localparam logic [15:0] PKT_PIX_CNT  = 16'(PKT_PIXELS);
    localparam logic [11:0] FRAME_PKTS_W = 12'(FRAME_PKTS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [23:0]       hold_pix_q, hold_pix_d;
    logic              hold_vld_q, hold_vld_d;
    logic [15:0]       pix_cnt_q, pix_cnt_d;
    logic [11:0]       pkt_cnt_q, pkt_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              sync_q, sync_d;
    logic              done_q, done_d;

    logic              is_marker;
    logic              is_video;
    logic              pkt_good;
    logic              pix_due;
    logic              flush_due;
    logic              wr_due;
    logic              last_pkt;
    logic              err_inc;
    logic [PIX_W-1:0]  pix_out;

    assign is_marker = bus.rec_pkt_done && (bus.rec_byte_num == 16'd4) && (bus.rec_data == FRAME_MARK);
    assign is_video  = bus.rec_pkt_done && !is_marker;
    assign pkt_good  = is_video && (bus.rec_byte_num == PKT_BYTES) && (pix_cnt_q == PKT_PIX_CNT);
    // A new strobe displaces the held pixel; a good packet end flushes it.
    // The parser never strobes a pixel in the same cycle as rec_pkt_done.
    assign pix_due   = bus.eth_rec_en && hold_vld_q;
    assign flush_due = pkt_good && hold_vld_q;
    assign wr_due    = (state_q == S_FRAME) && (pix_due || flush_due);
    assign last_pkt  = (pkt_cnt_q + 12'd1) == FRAME_PKTS_W;

`ifdef VIDEO_RX_RGB565_EN
    assign pix_out = {hold_pix_q[23:19], hold_pix_q[15:10], hold_pix_q[7:3]};
`else
    assign pix_out = hold_pix_q;
`endif

    always_comb begin
        state_d    = state_q;
        hold_pix_d = hold_pix_q;
        hold_vld_d = hold_vld_q;
        pix_cnt_d  = pix_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        sync_d     = 1'b0;
        done_d     = 1'b0;
        err_inc    = 1'b0;

        if (bus.eth_rec_en) begin
            hold_pix_d = bus.rec_data_24;
            hold_vld_d = 1'b1;
            if (pix_cnt_q != 16'hFFFF) begin
                pix_cnt_d = pix_cnt_q + 16'd1;
            end
        end
        if (bus.rec_pkt_done) begin
            hold_vld_d = 1'b0;
            pix_cnt_d  = 16'd0;
        end

        if (wr_due) begin
            if (bus.fifo_full) begin
                err_inc = 1'b1;
                state_d = S_DROP;
            end else begin
                wr_en_d   = 1'b1;
                wr_data_d = pix_out;
            end
        end

        case (state_q)
            S_IDLE, S_DROP: begin
                if (is_marker) begin
                    state_d   = S_FRAME;
                    sync_d    = 1'b1;
                    pkt_cnt_d = 12'd0;
                end
            end
            S_FRAME: begin
                if (is_marker) begin
                    // Restart: the frame in progress is abandoned and counted as an error.
                    sync_d    = 1'b1;
                    pkt_cnt_d = 12'd0;
                    err_inc   = 1'b1;
                end else if (is_video && !pkt_good) begin
                    state_d = S_DROP;
                    err_inc = 1'b1;
                end else if (pkt_good && !bus.fifo_full) begin
                    pkt_cnt_d = pkt_cnt_q + 12'd1;
                    if (last_pkt) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_pix_q <= 24'd0;
            hold_vld_q <= 1'b0;
            pix_cnt_q  <= 16'd0;
            pkt_cnt_q  <= 12'd0;
            err_cnt_q  <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            sync_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_pix_q <= hold_pix_d;
            hold_vld_q <= hold_vld_d;
            pix_cnt_q  <= pix_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            sync_q     <= sync_d;
            done_q     <= done_d;
        end
    end

    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign frame_sync       = sync_q;
    assign frame_done       = done_q;
    assign frame_active     = (state_q == S_FRAME);
    assign pkt_cnt          = pkt_cnt_q;
    assign err_cnt          = err_cnt_q;
    assign dbg_state        = state_q;
endmodule
